// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//
// Read-side consumer for a dual-clock FIFO. It runs entirely in the read
// clock domain. It drains the FIFO's registered read port and presents the
// words as a valid/ready stream. A 2-entry output buffer covers the FIFO's
// one-cycle read latency, so the stream sustains one word per cycle. Packet
// boundaries are marked every PKT_LEN words, and word and packet counters
// are kept for status.
//
// Handshake: a word transfers on every rising rclk edge where
// m_valid = 1 and m_ready = 1. Once m_valid is raised, it stays high and
// m_data/m_last stay stable until that transfer happens.
//
// Ports:
//   rclk        read-domain clock (the only clock)
//   rrst_n      asynchronous active-low reset; release is synchronous to rclk
//   fifo_empty  FIFO empty flag, synchronous to rclk
//   fifo_rdata  FIFO data_out; valid the cycle after a granted read
//   fifo_r_en   FIFO read enable (combinational, depends on m_ready)
//   m_valid     output word valid
//   m_ready     downstream accept
//   m_data      output word
//   m_last      last word of a packet, qualified by m_valid
//   word_cnt    words accepted downstream, wraps modulo 2^16
//   pkt_cnt     packets completed, wraps modulo 2^16
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [15:0]           word_cnt,
    output logic [15:0]           pkt_cnt
);

    localparam logic [15:0] LAST_POS = 16'(PKT_LEN - 1);

    logic [1:0]            occ;        // entries held in the output buffer
    logic                  inflight;   // a read was granted last cycle
    logic [DATA_WIDTH-1:0] head_q;     // oldest buffered word
    logic [DATA_WIDTH-1:0] tail_q;     // second buffered word
    logic [15:0]           pos;        // index within the current packet
    logic [15:0]           word_cnt_q;
    logic [15:0]           pkt_cnt_q;

    logic                  pop;
    logic [2:0]            committed;  // slots still claimed after this cycle's pop

    assign m_valid  = (occ != 2'd0);
    assign pop      = m_valid & m_ready;

    // Every buffered word and every word still in the FIFO read pipeline
    // holds a slot. A pop in this cycle frees its slot right away. This is
    // why m_ready reaches fifo_r_en combinationally and why reads resume in
    // the same cycle a stall releases.
    assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_r_en = rrst_n & ~fifo_empty & (committed < 3'd2);

    assign m_data   = head_q;
    assign m_last   = m_valid & (pos == LAST_POS);
    assign word_cnt = word_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ        <= 2'd0;
            inflight   <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            pos        <= 16'd0;
            word_cnt_q <= 16'd0;
            pkt_cnt_q  <= 16'd0;
        end else begin
            inflight <= fifo_r_en;
            // The arriving word is added and the popped word removed.
            occ      <= committed[1:0];

            // Shift-style buffer: head_q is always the oldest entry. With
            // the slot limit, a word cannot arrive into a full buffer
            // unless a pop happens in the same cycle.
            if (pop) begin
                if (occ == 2'd2) begin
                    head_q <= tail_q;
                    if (inflight) begin
                        tail_q <= fifo_rdata;
                    end
                end else if (inflight) begin
                    head_q <= fifo_rdata;
                end
            end else if (inflight) begin
                if (occ == 2'd0) begin
                    head_q <= fifo_rdata;
                end else begin
                    tail_q <= fifo_rdata;
                end
            end

            if (pop) begin
                word_cnt_q <= word_cnt_q + 16'd1;
                if (m_last) begin
                    pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    pos       <= 16'd0;
                end else begin
                    pos <= pos + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader.
// Two instances share one FIFO model: dut_a uses PKT_LEN = 16, and dut_b
// uses PKT_LEN = 1. Only the selected instance sees the FIFO and m_ready.
// The other instance sees an empty FIFO and m_ready = 0, so it stays idle.
module tb_fifo_stream_reader;

    localparam int DW = 8;

    logic rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic          rrst_n;
    logic          fifo_empty;
    logic          m_ready;
    logic [DW-1:0] fifo_rdata;
    logic          sel;

    logic          a_empty, a_ready, a_ren, a_valid, a_last;
    logic [DW-1:0] a_data;
    logic [15:0]   a_wcnt, a_pcnt;
    logic          b_empty, b_ready, b_ren, b_valid, b_last;
    logic [DW-1:0] b_data;
    logic [15:0]   b_wcnt, b_pcnt;

    assign a_empty = sel ? 1'b1 : fifo_empty;
    assign a_ready = sel ? 1'b0 : m_ready;
    assign b_empty = sel ? fifo_empty : 1'b1;
    assign b_ready = sel ? m_ready : 1'b0;

    logic          d_ren, d_valid, d_last;
    logic [DW-1:0] d_data;
    logic [15:0]   d_wcnt, d_pcnt;
    assign d_ren   = sel ? b_ren   : a_ren;
    assign d_valid = sel ? b_valid : a_valid;
    assign d_last  = sel ? b_last  : a_last;
    assign d_data  = sel ? b_data  : a_data;
    assign d_wcnt  = sel ? b_wcnt  : a_wcnt;
    assign d_pcnt  = sel ? b_pcnt  : a_pcnt;

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(16)) dut_a (
        .rclk(rclk), .rrst_n(rrst_n), .fifo_empty(a_empty), .fifo_rdata(fifo_rdata),
        .fifo_r_en(a_ren), .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data),
        .m_last(a_last), .word_cnt(a_wcnt), .pkt_cnt(a_pcnt)
    );

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1)) dut_b (
        .rclk(rclk), .rrst_n(rrst_n), .fifo_empty(b_empty), .fifo_rdata(fifo_rdata),
        .fifo_r_en(b_ren), .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data),
        .m_last(b_last), .word_cnt(b_wcnt), .pkt_cnt(b_pcnt)
    );

    // ---------------- model state ----------------
    logic [DW-1:0] fq[$];      // FIFO contents not yet read
    logic [DW-1:0] exp_q[$];   // words read from the FIFO, not yet accepted
    int            exp_t[$];   // cycle in which each of those words was read
    logic [15:0]   m_wcnt, m_pcnt, m_pos;
    int            cyc;
    int            total, bad;
    bit            hold_prev;
    logic [DW-1:0] hold_data;

    // per-phase statistics
    int            n_pops, n_reads, n_valid, n_last_pops;
    int            first_ren, first_val, last_val;
    logic          first_last;
    bit            first_pop_seen;
    logic          last_valid_sample;
    logic [DW-1:0] last_words[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mark();
        n_pops = 0; n_reads = 0; n_valid = 0; n_last_pops = 0;
        first_ren = -1; first_val = -1; last_val = -1;
        first_last = 1'bx; first_pop_seen = 0;
        last_words.delete();
    endtask

    // One rclk period. Inputs change at the falling edge. Outputs are sampled
    // 1 time unit later, so the FIFO model reacts at the next rising edge.
    task automatic run_cycle(input bit rdy);
        int            pkt;
        bit            exp_valid, pop, exp_ren, rd;
        logic [DW-1:0] d;
        @(negedge rclk);
        m_ready    = rdy;
        fifo_empty = (fq.size() == 0);
        #1;
        cyc++;
        pkt       = sel ? 1 : 16;
        // A word read in cycle t becomes visible in cycle t+2.
        exp_valid = (exp_q.size() > 0) && (exp_t[0] <= cyc - 2);
        pop       = exp_valid && rdy;
        // Words that are read but not yet accepted never exceed two,
        // counting the one accepted in this cycle.
        exp_ren   = (rrst_n === 1'b1) && (fq.size() != 0) &&
                    ((exp_q.size() - (pop ? 1 : 0)) < 2);

        check("m_valid", 32'(d_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("m_data", 32'(d_data), 32'(exp_q[0]));
            check("m_last", 32'(d_last), 32'(m_pos == 16'(pkt - 1)));
        end
        if (hold_prev) check("stall_hold", 32'(d_data), 32'(hold_data));
        hold_prev = exp_valid && !rdy;
        hold_data = d_data;
        check("fifo_r_en", 32'(d_ren), 32'(exp_ren));
        check("word_cnt", 32'(d_wcnt), 32'(m_wcnt));
        check("pkt_cnt", 32'(d_pcnt), 32'(m_pcnt));

        last_valid_sample = d_valid;
        if (d_valid === 1'b1) begin
            n_valid++;
            if (first_val < 0) first_val = cyc;
            last_val = cyc;
        end
        if (d_ren === 1'b1) begin
            n_reads++;
            if (first_ren < 0) first_ren = cyc;
        end

        if (pop) begin
            if (!first_pop_seen) begin
                first_last     = d_last;
                first_pop_seen = 1;
            end
            if (d_last === 1'b1) begin
                n_last_pops++;
                last_words.push_back(d_data);
            end
            void'(exp_q.pop_front());
            void'(exp_t.pop_front());
            n_pops++;
            m_wcnt = m_wcnt + 16'd1;
            if (m_pos == 16'(pkt - 1)) begin
                m_pcnt = m_pcnt + 16'd1;
                m_pos  = 16'd0;
            end else begin
                m_pos = m_pos + 16'd1;
            end
        end

        rd = (d_ren === 1'b1) && (fq.size() != 0);
        d  = '0;
        if (rd) begin
            d = fq.pop_front();
            exp_q.push_back(d);
            exp_t.push_back(cyc);
        end
        check("outstanding_le_2", 32'(exp_q.size() <= 2), 32'd1);

        @(posedge rclk);
        if (rd) fifo_rdata <= d;
    endtask

    // mode 0: m_ready held at 1; mode 1: m_ready pattern 1,0,0,1 repeating
    task automatic run_stream(input int nwords, input int mode, input int budget);
        int k;
        k = 0;
        while (n_pops < nwords && k < budget) begin
            if (mode == 0) run_cycle(1'b1);
            else run_cycle((k % 4 == 0) || (k % 4 == 3));
            k++;
        end
        check("stream_done_in_budget", 32'(n_pops), 32'(nwords));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b1);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        sel = 1'b0; rrst_n = 1'b0; fifo_empty = 1'b1; m_ready = 1'b0; fifo_rdata = '0;
        m_wcnt = 0; m_pcnt = 0; m_pos = 0; hold_prev = 0; hold_data = '0;
        last_valid_sample = 1'b0;
        mark();

        // ---- reset state ----
        #12;
        check("rst_fifo_r_en", 32'(a_ren), 32'd0);
        check("rst_m_valid", 32'(a_valid), 32'd0);
        check("rst_m_data", 32'(a_data), 32'd0);
        check("rst_m_last", 32'(a_last), 32'd0);
        check("rst_word_cnt", 32'(a_wcnt), 32'd0);
        check("rst_pkt_cnt", 32'(a_pcnt), 32'd0);
        @(negedge rclk);
        rrst_n = 1'b1;

        // ---- streaming: 0x00..0x1F, PKT_LEN 16, m_ready 1 ----
        mark();
        for (int i = 0; i < 32; i++) fq.push_back(8'(i));
        run_stream(32, 0, 100);
        drain(4);
        check("stream_first_latency", 32'(first_val - first_ren), 32'd2);
        check("stream_valid_cycles", 32'(n_valid), 32'd32);
        check("stream_valid_span", 32'(last_val - first_val), 32'd31);
        check("stream_word_cnt", 32'(a_wcnt), 32'd32);
        check("stream_pkt_cnt", 32'(a_pcnt), 32'd2);
        check("stream_last_count", 32'(last_words.size()), 32'd2);
        if (last_words.size() == 2) begin
            check("stream_last_word0", 32'(last_words[0]), 32'h0F);
            check("stream_last_word1", 32'(last_words[1]), 32'h1F);
        end

        // ---- backpressure: 40 words, m_ready 1,0,0,1 ----
        mark();
        for (int i = 0; i < 40; i++) fq.push_back(8'(8'h40 + i));
        run_stream(40, 1, 300);
        drain(4);
        check("bp_word_cnt", 32'(a_wcnt), 32'd72);
        check("bp_pkt_cnt", 32'(a_pcnt), 32'd4);
        check("bp_reads", 32'(n_reads), 32'd40);

        // ---- empty boundary: 3 words, stall 10 cycles, then release ----
        mark();
        fq.push_back(8'hA0); fq.push_back(8'hA1); fq.push_back(8'hA2);
        for (int i = 0; i < 10; i++) run_cycle(1'b0);
        check("eb_stall_reads", 32'(n_reads), 32'd2);
        run_cycle(1'b1);
        check("eb_release_read", 32'(n_reads), 32'd3);
        check("eb_release_pop", 32'(n_pops), 32'd1);
        drain(3);
        check("eb_pops", 32'(n_pops), 32'd3);
        check("eb_valid_dropped", 32'(last_valid_sample), 32'd0);
        check("eb_no_extra_reads", 32'(n_reads), 32'd3);
        check("eb_word_cnt", 32'(a_wcnt), 32'd75);

        // ---- mid-stream reset: buffer and read pipeline both occupied ----
        mark();
        for (int i = 0; i < 20; i++) fq.push_back(8'(8'hC0 + i));
        for (int i = 0; i < 6; i++) run_cycle(1'b1);
        check("pre_rst_outstanding", 32'(exp_q.size()), 32'd2);
        #3;
        rrst_n = 1'b0;
        #1;
        check("arst_fifo_r_en", 32'(a_ren), 32'd0);
        check("arst_m_valid", 32'(a_valid), 32'd0);
        check("arst_m_data", 32'(a_data), 32'd0);
        check("arst_m_last", 32'(a_last), 32'd0);
        check("arst_word_cnt", 32'(a_wcnt), 32'd0);
        check("arst_pkt_cnt", 32'(a_pcnt), 32'd0);
        fq.delete(); exp_q.delete(); exp_t.delete();
        m_wcnt = 0; m_pcnt = 0; m_pos = 0; hold_prev = 0;
        fifo_empty = 1'b1; fifo_rdata = '0;
        run_cycle(1'b1);
        run_cycle(1'b1);
        @(negedge rclk);
        rrst_n = 1'b1;
        mark();
        for (int i = 0; i < 4; i++) fq.push_back(8'(8'hD0 + i));
        run_stream(4, 0, 50);
        drain(4);
        check("post_rst_first_last", 32'(first_last), 32'd0);
        check("post_rst_word_cnt", 32'(a_wcnt), 32'd4);
        check("post_rst_pkt_cnt", 32'(a_pcnt), 32'd0);

        // ---- PKT_LEN 1, 65537 words, counters wrap ----
        sel = 1'b1;
        hold_prev = 0;
        m_wcnt = 0; m_pcnt = 0; m_pos = 0;
        mark();
        for (int i = 0; i < 65537; i++) fq.push_back(8'(i));
        run_stream(65537, 0, 66000);
        drain(4);
        check("wrap_first_last", 32'(first_last), 32'd1);
        check("wrap_last_every_word", 32'(n_last_pops), 32'd65537);
        check("wrap_word_cnt", 32'(b_wcnt), 32'd1);
        check("wrap_pkt_cnt", 32'(b_pcnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
